stream_burst_tx: RTL
====================

STREAM_BURST_TX -- requirements
Module: stream_burst_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of burst data words.
REQ-002 Parameter LEN_WIDTH, default 8, width of the burst length field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  burst command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_base  input  DATA_WIDTH  data value of first beat.
REQ-008 cmd_len  input  LEN_WIDTH  beats in burst minus one.
REQ-009 cmd_step  input  8  unsigned increment added between beats.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  DATA_WIDTH  beat payload.
REQ-013 out_last  output  1  marks final beat of burst.
REQ-014 busy  output  1  high while a burst is in progress (state SEND).
REQ-015 burst_done  output  1  one-cycle pulse after the final beat's handshake.

Function
REQ-016 Two-state FSM, IDLE and SEND; IDLE after reset.
REQ-017 Command handshake = cmd_valid && cmd_ready; output handshake = out_valid && out_ready.
REQ-018 cmd_ready SHALL be 1 in IDLE, and 1 in SEND only when out_valid && out_last && out_ready; 0 otherwise.
REQ-019 On command handshake: load out_data <= cmd_base, remaining <= cmd_len, step <= cmd_step; enter/stay SEND; out_valid = 1 the following cycle (latency one cycle).
REQ-020 Burst length SHALL be cmd_len+1 beats; cmd_len=0 gives one beat; cmd_len=2^LEN_WIDTH-1 gives 2^LEN_WIDTH beats.
REQ-021 out_valid SHALL equal (state == SEND); it never deasserts without an output handshake.
REQ-022 While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-023 On a non-final output handshake: out_data <= out_data + zero-extended step, modulo 2^DATA_WIDTH (wrap, no saturation); remaining decrements by 1.
REQ-024 out_last SHALL be 1 exactly when out_valid && remaining == 0.
REQ-025 On the final-beat handshake with no command handshake in the same cycle: go to IDLE; out_valid = 0 next cycle.
REQ-026 On the final-beat handshake with cmd_valid = 1 in the same cycle: load the new command per REQ-019, stay SEND, first beat of new burst presented next cycle (zero bubble).
REQ-027 burst_done SHALL be registered, high exactly one cycle following each final-beat handshake, including back-to-back bursts.
REQ-028 Command fields SHALL be sampled only at command handshake; changes on cmd_* at other times have no effect.
REQ-029 out_ready asserted while out_valid = 0 has no effect.

Reset
REQ-030 While rst_n = 0: state IDLE, out_valid 0, out_last 0, out_data 0, busy 0, burst_done 0, remaining and step 0; cmd_ready 1.
REQ-031 Assertion of rst_n mid-burst SHALL drop out_valid immediately (asynchronously) and discard the rest of the burst; no residual beats after release.
REQ-032 First command accepted on the first rising edge with rst_n = 1 and cmd_valid = 1.

Verification
REQ-033 base=0x10, len=3, step=4, out_ready=1 -> beats 0x10,0x14,0x18,0x1C on consecutive cycles, out_last only on 0x1C, burst_done one cycle later, busy 0 after.
REQ-034 Same burst, out_ready=0 for 3 cycles while 0x14 presented -> out_valid=1 and out_data=0x14 held all 3 cycles, then 0x18 follows; 4 beats total.
REQ-035 Second command (base=0x100, len=1, step=1) valid during first burst's last beat -> cmd_ready=1 that cycle, 0x100 presented the next cycle, no out_valid gap, two burst_done pulses.
REQ-036 base=0xFFFFFFFE, len=2, step=1 -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, last on third.
REQ-037 len=0, base=0xAA -> single beat 0xAA with out_last=1, state IDLE the cycle after handshake.
REQ-038 rst_n pulsed low during beat 2 of a len=7 burst -> out_valid 0 immediately, cmd_ready 1, no further beats until a new command.

Source files
------------

// File: rtl/stream_burst_tx.sv
// Burst generator: takes a (base, len, step) command and emits len+1 beats on a
// valid/ready stream, with zero-bubble chaining of back-to-back commands.
module stream_burst_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [7:0]            cmd_step,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  burst_done
);

  // state | meaning
  // IDLE  | no burst active, waiting for a command
  // SEND  | presenting beats of the current burst
  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_r, state_nxt;
  logic [DATA_WIDTH-1:0] data_r, data_nxt;
  logic [LEN_WIDTH-1:0]  rem_r, rem_nxt;
  logic [7:0]            step_r, step_nxt;
  logic                  done_r;

  logic cmd_hs, out_hs, final_hs;

  // out_valid is decoded straight from state so async reset drops it at once
  assign out_valid  = (state_r == SEND);
  assign out_last   = out_valid && (rem_r == '0);
  assign busy       = out_valid;
  assign out_data   = data_r;
  assign burst_done = done_r;

  assign out_hs    = out_valid && out_ready;
  assign final_hs  = out_hs && out_last;
  assign cmd_ready = (state_r == IDLE) || final_hs;
  assign cmd_hs    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      data_r  <= '0;
      rem_r   <= '0;
      step_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      data_r  <= data_nxt;
      rem_r   <= rem_nxt;
      step_r  <= step_nxt;
      done_r  <= final_hs;
    end
  end

  always_comb begin
    state_nxt = state_r;
    data_nxt  = data_r;
    rem_nxt   = rem_r;
    step_nxt  = step_r;
    if (cmd_hs) begin
      state_nxt = SEND;
      data_nxt  = cmd_base;
      rem_nxt   = cmd_len;
      step_nxt  = cmd_step;
    end else if (final_hs) begin
      state_nxt = IDLE;
    end else if (out_hs) begin
      data_nxt = data_r + DATA_WIDTH'(step_r);
      rem_nxt  = rem_r - 1'b1;
    end
  end

endmodule
